// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - FIFO-buffered UART transmitter paced by baud_tick
module uart_tx_buffered #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              baud_tick,
    input  logic [DATA_BITS-1:0]              data_in,
    input  logic                              data_valid_in,
    output logic                              ready_out,
    output logic                              tx,
    output logic                              tx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [DATA_BITS-1:0]   shift;
    logic [BW-1:0]          bit_cnt;
    logic                   stop_cnt;
    logic                   parity_bit;
    logic [DATA_BITS-1:0]   head;
    logic                   push;
    logic                   pop;
    logic                   fifo_empty;
    logic                   stop_done;

    // Ready depends only on the registered count, so a same-cycle pop never frees a slot
    assign ready_out  = (fifo_count != CW'(FIFO_DEPTH));
    assign push       = data_valid_in && ready_out;
    assign fifo_empty = (fifo_count == '0);
    assign head       = mem[rd_ptr];
    assign stop_done  = (stop_cnt == 1'(STOP_BITS - 1));
    // A pop only ever happens where a new frame begins: from idle or at the end of the last stop bit
    assign pop        = baud_tick && !fifo_empty &&
                        ((state == S_IDLE) || ((state == S_STOP) && stop_done));

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame FSM; every state change and tx update happens only on a baud tick
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            shift      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
        end else if (baud_tick) begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift      <= head;
                        parity_bit <= (PARITY == 1) ? ~^head : ^head;
                        tx         <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    tx      <= shift[0];
                    shift   <= shift >> 1;
                    bit_cnt <= '0;
                    state   <= S_DATA;
                end
                S_DATA: begin
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            tx    <= parity_bit;
                            state <= S_PARITY;
                        end else begin
                            tx       <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= S_STOP;
                        end
                    end else begin
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                S_PARITY: begin
                    tx       <= 1'b1;
                    stop_cnt <= 1'b0;
                    state    <= S_STOP;
                end
                S_STOP: begin
                    if (!stop_done) begin
                        stop_cnt <= stop_cnt + 1'b1;
                    end else if (pop) begin
                        // Back-to-back frame: the start bit begins on the tick ending the stop bit
                        shift      <= head;
                        parity_bit <= (PARITY == 1) ? ~^head : ^head;
                        tx         <= 1'b0;
                        state      <= S_START;
                    end else begin
                        tx_busy <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_in;
    logic       baud_tick;
    logic [7:0] data_in;
    logic       valid_main;
    logic       valid_par;

    logic       ready_main, tx_main, busy_main;
    logic [4:0] count_main;
    logic       ready_ev, tx_ev, busy_ev;
    logic [4:0] count_ev;
    logic       ready_od, tx_od, busy_od;
    logic [4:0] count_od;

    uart_tx_buffered #(.DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) dut_main (
        .clk_in(clk), .rst_in(rst_in), .baud_tick(baud_tick), .data_in(data_in),
        .data_valid_in(valid_main), .ready_out(ready_main), .tx(tx_main),
        .tx_busy(busy_main), .fifo_count(count_main)
    );

    uart_tx_buffered #(.DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(2)) dut_even (
        .clk_in(clk), .rst_in(rst_in), .baud_tick(baud_tick), .data_in(data_in),
        .data_valid_in(valid_par), .ready_out(ready_ev), .tx(tx_ev),
        .tx_busy(busy_ev), .fifo_count(count_ev)
    );

    uart_tx_buffered #(.DATA_BITS(8), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(1)) dut_odd (
        .clk_in(clk), .rst_in(rst_in), .baud_tick(baud_tick), .data_in(data_in),
        .data_valid_in(valid_par), .ready_out(ready_od), .tx(tx_od),
        .tx_busy(busy_od), .fifo_count(count_od)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // line bits in time order, bit 0 = start bit
    } vec_t;

    vec_t       vecs [7];
    int         n_checks = 0;
    int         n_fail   = 0;
    bit         tick_en     = 1'b0;
    bit         edge_chk_en = 1'b0;
    bit         edge_err    = 1'b0;
    bit         cnt_err     = 1'b0;
    int         div;
    logic       last_tx;
    logic [9:0] mon_f;
    logic [9:0] mon_q [$];
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Baud tick generator (one pulse every 16 clocks) plus line-edge and occupancy watchers
    initial begin
        baud_tick = 1'b0;
        div       = 0;
        last_tx   = 1'b1;
        forever begin
            @(negedge clk);
            if (edge_chk_en && (tx_main !== last_tx) && (baud_tick !== 1'b1)) edge_err = 1'b1;
            last_tx = tx_main;
            if (count_main > 5'd16) cnt_err = 1'b1;
            if (tick_en) begin
                div       = (div == 15) ? 0 : div + 1;
                baud_tick = (div == 15);
            end else begin
                baud_tick = 1'b0;
            end
        end
    end

    // Line monitor for the 8N1 instance: samples each bit at its middle
    initial begin
        forever begin
            @(negedge clk);
            if (tx_main === 1'b0) begin
                repeat (8) @(negedge clk);
                mon_f[0] = tx_main;
                for (int b = 1; b < 10; b++) begin
                    repeat (16) @(negedge clk);
                    mon_f[b] = tx_main;
                end
                mon_q.push_back(mon_f);
            end
        end
    end

    task automatic push_main(input logic [7:0] d);
        data_in    = d;
        valid_main = 1'b1;
        @(negedge clk);
        valid_main = 1'b0;
    endtask

    task automatic wait_tick();
        int t = 0;
        while (baud_tick !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    task automatic measure_busy(output int len, output int cnt_at_rise);
        int t = 0;
        len = 0;
        while (busy_main !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        cnt_at_rise = int'(count_main);
        while (busy_main === 1'b1 && len < 2000) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (mon_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("frames_received", mon_q.size(), n);
    endtask

    initial begin
        int         len;
        int         cnt0;
        int         t;
        int         n_acc;
        bit         acc;
        bit         flag;
        logic [7:0] d;
        logic [11:0] pe;
        logic [11:0] po;

        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'h3C, 10'b1001111000};
        vecs[3] = '{8'h81, 10'b1100000010};
        vecs[4] = '{8'h55, 10'b1010101010};
        vecs[5] = '{8'h0F, 10'b1000011110};
        vecs[6] = '{8'hFF, 10'b1111111110};

        rst_in     = 1'b1;
        valid_main = 1'b0;
        valid_par  = 1'b0;
        data_in    = 8'h00;
        repeat (3) @(negedge clk);
        rst_in = 1'b0;
        @(negedge clk);
        check("reset_tx", tx_main, 1);
        check("reset_busy", busy_main, 0);
        check("reset_count", count_main, 0);
        check("reset_ready", ready_main, 1);
        edge_chk_en = 1'b1;
        tick_en     = 1'b1;

        // Single frames, one byte at a time
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            push_main(vecs[i].data);
            check("count_after_push", count_main, 1);
            measure_busy(len, cnt0);
            check("count_at_start", cnt0, 0);
            check("busy_len_single", len, 160);
            wait_frames(1, 200);
            if (mon_q.size() > 0) check("frame_single", mon_q.pop_front(), vecs[i].frame);
        end

        // Three bytes on consecutive cycles: frames must be back to back
        wait_tick();
        push_main(vecs[4].data);
        push_main(vecs[5].data);
        push_main(vecs[6].data);
        measure_busy(len, cnt0);
        check("busy_len_burst", len, 480);
        wait_frames(3, 200);
        for (int i = 4; i < 7; i++) begin
            if (mon_q.size() > 0) check("frame_burst", mon_q.pop_front(), vecs[i].frame);
        end

        // Fill with ticks frozen: the 17th byte is dropped
        tick_en = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) push_main(8'h30 + 8'(i));
        check("full_ready", ready_main, 0);
        check("full_count", count_main, 16);
        check("frozen_busy", busy_main, 0);
        push_main(8'hEE);
        check("drop_count", count_main, 16);
        mon_q.delete();
        tick_en = 1'b1;
        wait_frames(16, 16 * 160 + 400);
        repeat (400) @(negedge clk);
        check("no_extra_frame", mon_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            d = 8'h30 + 8'(i);
            if (mon_q.size() > 0) check("frame_fill_order", mon_q.pop_front(), {1'b1, d, 1'b0});
        end
        check("drained_count", count_main, 0);

        // Parity instances: even parity with two stop bits, odd parity with one
        wait_tick();
        data_in   = 8'h07;
        valid_par = 1'b1;
        @(negedge clk);
        valid_par = 1'b0;
        t = 0;
        while (tx_ev !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("parity_start_seen", tx_ev, 0);
        repeat (8) @(negedge clk);
        for (int b = 0; b < 12; b++) begin
            pe[b] = tx_ev;
            po[b] = tx_od;
            repeat (16) @(negedge clk);
        end
        check("frame_even_parity", pe, 12'b111000001110);
        check("frame_odd_parity", po, 12'b110000001110);
        check("even_idle_after", {busy_ev, ready_ev, count_ev}, {1'b0, 1'b1, 5'd0});
        check("odd_idle_after", {busy_od, ready_od, count_od}, {1'b0, 1'b1, 5'd0});

        // Reset during data bit 3 of 0xAA with four bytes queued behind it
        wait_tick();
        push_main(8'hAA);
        push_main(8'h01);
        push_main(8'h02);
        push_main(8'h03);
        push_main(8'h04);
        t = 0;
        while (tx_main !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (72) @(negedge clk);
        check("data_bit3_before_reset", tx_main, 1);
        check("queued_before_reset", count_main, 4);
        edge_chk_en = 1'b0;
        rst_in      = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        check("midreset_tx", tx_main, 1);
        check("midreset_busy", busy_main, 0);
        check("midreset_count", count_main, 0);
        check("midreset_ready", ready_main, 1);
        flag = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (tx_main !== 1'b1 || busy_main !== 1'b0) flag = 1'b1;
        end
        check("quiet_after_reset", flag, 0);
        edge_chk_en = 1'b1;
        mon_q.delete();

        // 256 random bytes at random spacing, holding valid while the FIFO is full
        n_acc = 0;
        t     = 0;
        while (n_acc < 256 && t < 60000) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            data_in    = 8'($urandom);
            valid_main = 1'b1;
            acc        = 1'b0;
            while (!acc && t < 60000) begin
                if (ready_main === 1'b1) begin
                    exp_q.push_back(data_in);
                    acc = 1'b1;
                end
                @(negedge clk);
                t++;
            end
            valid_main = 1'b0;
            n_acc++;
        end
        check("random_all_accepted", exp_q.size(), 256);
        wait_frames(256, 4000);
        for (int i = 0; i < 256; i++) begin
            if (mon_q.size() > 0 && exp_q.size() > 0) begin
                d = exp_q.pop_front();
                check("frame_random", mon_q.pop_front(), {1'b1, d, 1'b0});
            end
        end
        check("count_never_over_depth", cnt_err, 0);
        check("tx_edges_only_on_tick", edge_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
FIFO-buffered UART transmitter. It is the sending end for the existing `receiver` module and is paced by `baud_tick` from `tick_generator`. Upstream logic pushes bytes through a valid/ready handshake. The block serialises them onto `tx` as back-to-back frames (start, data LSB-first, optional parity, stop), so the producer never has to wait on a busy line for each byte.

Parameters:
- DATA_BITS, 8: payload bits per frame (5..9).
- FIFO_DEPTH, 16: entries in the input FIFO (power of two, at least 2).
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: stop bits per frame (1 or 2).

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_in  input  1  synchronous, active-high reset.
- baud_tick  input  1  one-cycle pulse per bit period, from `tick_generator`.
- data_in  input  DATA_BITS  byte to enqueue.
- data_valid_in  input  1  `data_in` is valid this cycle.
- ready_out  output  1  FIFO can accept a byte; equals (fifo_count != FIFO_DEPTH).
- tx  output  1  serial line; idles high.
- tx_busy  output  1  high while the FSM is not in IDLE.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  number of bytes queued, excluding the frame in flight.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high on `rst_in`, sampled at the rising edge of `clk_in`.
- Reset values: tx=1, tx_busy=0, fifo_count=0, ready_out=1, FSM=IDLE, FIFO pointers=0, shift register=0.
- Reset mid-frame: the frame is abandoned, the FIFO is flushed, and tx=1 from the cycle after reset is sampled.
- Push: a byte is written when data_valid_in && ready_out at the clock edge. If data_valid_in is high while full, the byte is dropped and the FIFO and count are unchanged.
- Pop: occurs only at a frame start (see FSM). A push and a pop in the same cycle leave fifo_count unchanged.
- ready_out is computed from the registered count only. A pop in the current cycle does not free a slot for a push in that same cycle.
- Read timing: a byte pushed on cycle N is poppable from cycle N+1. If baud_tick coincides with the first push into an empty FIFO, no frame starts on that tick.
- All `tx` transitions occur on the clock edge at which baud_tick=1. Each bit lasts exactly one baud period.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. On baud_tick with FIFO non-empty: pop the head into the shift register, tx<=0, go to START.
  - START: on baud_tick: tx<=shift[0], shift right, bit_cnt<=0, go to DATA.
  - DATA: on baud_tick: if bit_cnt==DATA_BITS-1, go to PARITY when PARITY!=0 (driving the parity bit on tx), else go to STOP (tx<=1). Otherwise drive the next bit and increment bit_cnt.
  - PARITY: even parity = XOR of the data bits; odd parity = its inverse. On baud_tick: tx<=1, go to STOP.
  - STOP: held for STOP_BITS baud periods. On the baud_tick ending the last stop bit: if the FIFO is non-empty, pop and drive tx<=0 on that same edge (START, no idle gap); else go to IDLE (tx stays 1).
- Parity is computed from the latched byte at pop, never from `data_in`.
- Frame length: 1 + DATA_BITS + (PARITY!=0) + STOP_BITS baud periods. For 8N1 that is 10.
- baud_tick held low: the FSM freezes in its current state with tx stable; pushes continue.
- fifo_count wraps never; the FIFO pointers wrap modulo FIFO_DEPTH.
- `tx` is a registered output with no combinational path from the inputs.

Test Plan:
- 8N1, baud_tick every 16 cycles, push 0xA5 once -> tx shows 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles. tx_busy high for 160 cycles. fifo_count goes 1 to 0 at the start bit.
- Push 0x55, 0x0F, 0xFF on consecutive cycles -> three frames with no idle cycles between stop and start. The next start bit begins on the tick ending the prior stop bit. tx_busy is continuous for 480 cycles.
- baud_tick held low, push 17 bytes -> ready_out drops after the 16th. The 17th is discarded and fifo_count=16. Then enable ticks -> exactly 16 frames in push order.
- PARITY=2, push 0x07 -> parity bit 1. With PARITY=1 the parity bit is 0. A `receiver` instance decodes 0x07 with data_valid.
- Assert rst_in for one cycle during the data bit 3 of 0xAA with 4 bytes queued -> next cycle tx=1, tx_busy=0, fifo_count=0. No further frames are sent.
- Loopback to `receiver` with 256 random bytes at random push spacing -> the received sequence equals the pushed sequence, no data_valid is missed, and fifo_count never exceeds 16.
